decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL: if_instr  in  32  IF/ID instruction word.
REQ-004 SHALL: if_pc4  in  32  IF/ID PC+4.
REQ-005 SHALL: if_valid  in  1  IF/ID holds a real instruction.
REQ-006 SHALL: ex_memread  in  1  instruction now in EX is a load.
REQ-007 SHALL: ex_rt  in  5  destination (rt) of the load now in EX.
REQ-008 SHALL: flush  in  1  EX resolved a taken branch (ALU out_branch).
REQ-009 SHALL: wb_regwrite, wb_addr[4:0], wb_data[31:0]  in  writeback port.
REQ-010 SHALL: stall  out  1  combinational; hold PC and IF/ID when high.
REQ-011 SHALL: idex_rd1, idex_rd2, idex_imm, idex_pc4  out  32 each  read data 1/2, sign-extended imm, PC+4.
REQ-012 SHALL: idex_rt, idex_rd  out  5 each  instr[20:16], instr[15:11] (feed the RegDst mux).
REQ-013 SHALL: idex_RegDst, idex_ALUSrc, idex_Branch, idex_MemRead, idex_MemWrite, idex_RegWrite, idex_MemtoReg  out  1 each.
REQ-014 SHALL: idex_ALUctrl  out  2  00 compare-equal, 01 add, 10 subtract, 11 unused.
REQ-015 SHALL: idex_illegal  out  1  valid but undecodable opcode/funct.

Function
REQ-016 SHALL: latency one cycle -- instruction present on if_instr before edge n appears on idex_* after edge n.
REQ-017 SHALL: decode: R-type 000000/funct 100000 -> ALUctrl 01, RegDst 1, RegWrite 1; funct 100010 -> ALUctrl 10, otherwise same.
REQ-018 SHALL: lw 100011 -> ALUctrl 01, ALUSrc 1, MemRead 1, RegWrite 1, MemtoReg 1, RegDst 0.
REQ-019 SHALL: sw 101011 -> ALUctrl 01, ALUSrc 1, MemWrite 1; addi 001000 -> ALUctrl 01, ALUSrc 1, RegWrite 1.
REQ-020 SHALL: beq 000100 -> ALUctrl 00, Branch 1; all other opcodes/functs -> all controls 0, idex_illegal 1.
REQ-021 SHALL: idex_imm = instr[15:0] sign-extended to 32 bits (bit 15 replicated).
REQ-022 SHALL: 32x32 register file, two combinational read ports (rs=instr[25:21], rt=instr[20:16]), one write port written at edge when wb_regwrite=1.
REQ-023 SHALL: register 0 reads 0 always; writes to address 0 ignored.
REQ-024 SHALL: stall = if_valid & ex_memread & ex_rt!=0 & (ex_rt==rs | ex_rt==rt).
REQ-025 SHALL: on stall, load a bubble (all control outputs and idex_illegal 0) into ID/EX; data fields don't-care.
REQ-026 SHALL: flush at edge loads a bubble into ID/EX; flush has priority over stall; stall output forced 0 while flush=1.
REQ-027 SHALL: if_valid=0 loads a bubble.
REQ-028 SHALL: writeback proceeds during stall, flush and bubble cycles.

Reset
REQ-029 SHALL: reset at edge clears every idex_* output and all 32 registers to 0; reset overrides flush, stall and writeback in that cycle.
REQ-030 SHALL: stall reads 0 while reset is high.

Configuration
REQ-031 SHALL: macro DECODE_WB_BYPASS_EN defined -> read port returns wb_data when wb_regwrite=1 and wb_addr equals nonzero read address (same-cycle bypass).
REQ-032 SHALL: macro undefined -> read ports return array contents only; same-cycle write visible from next cycle.

Verification
REQ-033 SHALL: reset high one edge, then if_valid=0 -> all idex_* 0, stall 0; read any register -> 0.
REQ-034 SHALL: write r8=0x0000_0005, r9=0xFFFF_FFFD, then decode sub r10,r8,r9 (0x0109_5022) -> idex_rd1=5, idex_rd2=0xFFFF_FFFD, ALUctrl 10, RegDst 1, idex_rd=10.
REQ-035 SHALL: decode lw r2,-4(r1) (0x8C22_FFFC) -> idex_imm=0xFFFF_FFFC, ALUSrc 1, MemRead 1, MemtoReg 1, idex_rt=2.
REQ-036 SHALL: ex_memread=1, ex_rt=2, if_instr add r3,r2,r4 -> stall 1 and bubble in ID/EX; same with flush=1 -> stall 0, bubble.
REQ-037 SHALL: wb_regwrite=1, wb_addr=7, wb_data=0x1234 in same cycle as decode reading r7 -> idex_rd1=0x1234 with DECODE_WB_BYPASS_EN, old value without.
REQ-038 SHALL: write r0=0xFFFF_FFFF, decode beq r0,r0 -> idex_rd1=idex_rd2=0, Branch 1, ALUctrl 00; opcode 111111 -> idex_illegal 1, controls 0.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: register file, main decoder, load-use hazard detect and ID/EX register.
// Optional same-cycle writeback bypass on the read ports: define DECODE_WB_BYPASS_EN.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc4,
    input  logic        if_valid,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        flush,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic [31:0] idex_rd1,
    output logic [31:0] idex_rd2,
    output logic [31:0] idex_imm,
    output logic [31:0] idex_pc4,
    output logic [4:0]  idex_rt,
    output logic [4:0]  idex_rd,
    output logic        idex_RegDst,
    output logic        idex_ALUSrc,
    output logic        idex_Branch,
    output logic        idex_MemRead,
    output logic        idex_MemWrite,
    output logic        idex_RegWrite,
    output logic        idex_MemtoReg,
    output logic [1:0]  idex_ALUctrl,
    output logic        idex_illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        unused_shamt;

    assign opcode       = if_instr[31:26];
    assign rs           = if_instr[25:21];
    assign rt           = if_instr[20:16];
    assign rd           = if_instr[15:11];
    assign funct        = if_instr[5:0];
    assign imm          = {{16{if_instr[15]}}, if_instr[15:0]};
    assign unused_shamt = ^if_instr[10:6];

    logic [31:0] regs [32];
    logic [31:0] rd1;
    logic [31:0] rd2;

    always_comb begin
        rd1 = (rs == 5'd0) ? 32'd0 : regs[rs];
        rd2 = (rt == 5'd0) ? 32'd0 : regs[rt];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_regwrite && wb_addr != 5'd0 && wb_addr == rs) begin
            rd1 = wb_data;
        end
        if (wb_regwrite && wb_addr != 5'd0 && wb_addr == rt) begin
            rd2 = wb_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_regwrite && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Load-use hazard; a taken-branch flush kills the instruction anyway.
    assign stall = !reset && !flush && if_valid && ex_memread &&
                   (ex_rt != 5'd0) && (ex_rt == rs || ex_rt == rt);

    logic       is_add;
    logic       is_sub;
    logic       is_lw;
    logic       is_sw;
    logic       is_addi;
    logic       is_beq;
    logic       c_regdst;
    logic       c_alusrc;
    logic       c_branch;
    logic       c_memread;
    logic       c_memwrite;
    logic       c_regwrite;
    logic       c_memtoreg;
    logic [1:0] c_aluctrl;
    logic       c_illegal;
    logic       bubble;

    assign is_add  = (opcode == 6'b000000) && (funct == 6'b100000);
    assign is_sub  = (opcode == 6'b000000) && (funct == 6'b100010);
    assign is_lw   = (opcode == 6'b100011);
    assign is_sw   = (opcode == 6'b101011);
    assign is_addi = (opcode == 6'b001000);
    assign is_beq  = (opcode == 6'b000100);

    always_comb begin
        c_regdst   = 1'b0;
        c_alusrc   = 1'b0;
        c_branch   = 1'b0;
        c_memread  = 1'b0;
        c_memwrite = 1'b0;
        c_regwrite = 1'b0;
        c_memtoreg = 1'b0;
        c_aluctrl  = 2'b00;
        c_illegal  = 1'b0;
        unique case (1'b1)
            is_add: begin
                c_aluctrl  = 2'b01;
                c_regdst   = 1'b1;
                c_regwrite = 1'b1;
            end
            is_sub: begin
                c_aluctrl  = 2'b10;
                c_regdst   = 1'b1;
                c_regwrite = 1'b1;
            end
            is_lw: begin
                c_aluctrl  = 2'b01;
                c_alusrc   = 1'b1;
                c_memread  = 1'b1;
                c_regwrite = 1'b1;
                c_memtoreg = 1'b1;
            end
            is_sw: begin
                c_aluctrl  = 2'b01;
                c_alusrc   = 1'b1;
                c_memwrite = 1'b1;
            end
            is_addi: begin
                c_aluctrl  = 2'b01;
                c_alusrc   = 1'b1;
                c_regwrite = 1'b1;
            end
            is_beq: begin
                c_aluctrl  = 2'b00;
                c_branch   = 1'b1;
            end
            default: begin
                c_illegal  = 1'b1;
            end
        endcase
    end

    assign bubble = flush || stall || !if_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_rd1      <= 32'd0;
            idex_rd2      <= 32'd0;
            idex_imm      <= 32'd0;
            idex_pc4      <= 32'd0;
            idex_rt       <= 5'd0;
            idex_rd       <= 5'd0;
            idex_RegDst   <= 1'b0;
            idex_ALUSrc   <= 1'b0;
            idex_Branch   <= 1'b0;
            idex_MemRead  <= 1'b0;
            idex_MemWrite <= 1'b0;
            idex_RegWrite <= 1'b0;
            idex_MemtoReg <= 1'b0;
            idex_ALUctrl  <= 2'b00;
            idex_illegal  <= 1'b0;
        end else begin
            idex_rd1 <= rd1;
            idex_rd2 <= rd2;
            idex_imm <= imm;
            idex_pc4 <= if_pc4;
            idex_rt  <= rt;
            idex_rd  <= rd;
            if (bubble) begin
                idex_RegDst   <= 1'b0;
                idex_ALUSrc   <= 1'b0;
                idex_Branch   <= 1'b0;
                idex_MemRead  <= 1'b0;
                idex_MemWrite <= 1'b0;
                idex_RegWrite <= 1'b0;
                idex_MemtoReg <= 1'b0;
                idex_ALUctrl  <= 2'b00;
                idex_illegal  <= 1'b0;
            end else begin
                idex_RegDst   <= c_regdst;
                idex_ALUSrc   <= c_alusrc;
                idex_Branch   <= c_branch;
                idex_MemRead  <= c_memread;
                idex_MemWrite <= c_memwrite;
                idex_RegWrite <= c_regwrite;
                idex_MemtoReg <= c_memtoreg;
                idex_ALUctrl  <= c_aluctrl;
                idex_illegal  <= c_illegal;
            end
        end
    end

endmodule
